// File: rtl/layer_scheduler_if.sv
// Run control, engine handshake and shared DRAM port of the layer scheduler.
// master is the scheduler side; slave is the software, engine and DRAM side.
interface layer_scheduler_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int NUM_LAYERS = 4,
  parameter int CNT_WIDTH  = 24
);
  localparam int IDX_W = $clog2(NUM_LAYERS + 1);

  logic                             start;
  logic [NUM_LAYERS-1:0]            layer_mask;
  logic [NUM_LAYERS-1:0]            layer_en;
  logic [NUM_LAYERS-1:0]            layer_done;
  logic [NUM_LAYERS*ADDR_WIDTH-1:0] layer_addr_in;
  logic [NUM_LAYERS*ADDR_WIDTH-1:0] layer_addr_out;
  logic [NUM_LAYERS*DATA_WIDTH-1:0] layer_data_out;
  logic [NUM_LAYERS-1:0]            layer_dram_en_rd;
  logic [NUM_LAYERS-1:0]            layer_dram_en_wr;
  logic [ADDR_WIDTH-1:0]            dram_addr_rd;
  logic [ADDR_WIDTH-1:0]            dram_addr_wr;
  logic [DATA_WIDTH-1:0]            dram_data_wr;
  logic                             dram_en_rd;
  logic                             dram_en_wr;
  logic                             busy;
  logic                             done;
  logic                             error;
  logic [IDX_W-1:0]                 cur_layer;
  logic [CNT_WIDTH-1:0]             last_cycles;

  modport master (
    input  start, layer_mask, layer_done, layer_addr_in, layer_addr_out, layer_data_out,
           layer_dram_en_rd, layer_dram_en_wr,
    output layer_en, dram_addr_rd, dram_addr_wr, dram_data_wr, dram_en_rd, dram_en_wr,
           busy, done, error, cur_layer, last_cycles
  );

  modport slave (
    output start, layer_mask, layer_done, layer_addr_in, layer_addr_out, layer_data_out,
           layer_dram_en_rd, layer_dram_en_wr,
    input  layer_en, dram_addr_rd, dram_addr_wr, dram_data_wr, dram_en_rd, dram_en_wr,
           busy, done, error, cur_layer, last_cycles
  );
endinterface

// File: rtl/layer_scheduler.sv
// Launches the attached layer engines in index order and lends the single DRAM port
// to whichever engine is currently running.
//   state  | meaning
//   IDLE   | waiting for start
//   SEL    | step past masked-off layers, one per cycle; finish after the last index
//   LAUNCH | one-cycle enable pulse to engine idx, cycle counter cleared
//   WAIT   | counting cycles until engine idx reports done, watchdog armed
//   DONE   | one-cycle completion pulse
//   ERR    | watchdog expired; DRAM released until the next start
module layer_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 18,
  parameter int NUM_LAYERS = 4,
  parameter int CNT_WIDTH  = 24,
  parameter int TIMEOUT    = 2**20
) (
  input logic               clk,
  input logic               rst,
  layer_scheduler_if.master bus
);
  localparam int IDX_W = $clog2(NUM_LAYERS + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [2:0] {S_IDLE, S_SEL, S_LAUNCH, S_WAIT, S_DONE, S_ERR} state_t;

  state_t                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_LAYERS-1:0] mask_q, mask_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0]  last_q, last_d;
  logic                  err_q, err_d;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  sel_mask;
  logic                  sel_done;
  logic                  serving;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
      last_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      cnt_q   <= cnt_d;
      last_q  <= last_d;
      err_q   <= err_d;
    end
  end

  // Saturating increment shared by the running count and the reported length.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  always_comb begin
    sel_mask = 1'b0;
    sel_done = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        sel_mask = mask_q[i];
        sel_done = bus.layer_done[i];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE, S_ERR: begin
        if (bus.start) begin
          mask_d  = bus.layer_mask;
          idx_d   = '0;
          err_d   = 1'b0;
          state_d = S_SEL;
        end
      end
      S_SEL: begin
        if (idx_q == IDX_W'(NUM_LAYERS)) begin
          state_d = S_DONE;
        end else if (!sel_mask) begin
          idx_d = idx_q + 1'b1;
        end else begin
          state_d = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        cnt_d = cnt_inc;
        if (sel_done) begin
          last_d  = cnt_inc;
          idx_d   = idx_q + 1'b1;
          state_d = S_SEL;
        end else if ((TIMEOUT != 0) && (cnt_q == CNT_LAST)) begin
          err_d   = 1'b1;
          state_d = S_ERR;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign serving = (state_q == S_LAUNCH) || (state_q == S_WAIT);

  // Only the engine at idx reaches the DRAM port, and only while it is being served.
  always_comb begin
    bus.layer_en     = '0;
    bus.dram_addr_rd = '0;
    bus.dram_addr_wr = '0;
    bus.dram_data_wr = '0;
    bus.dram_en_rd   = 1'b0;
    bus.dram_en_wr   = 1'b0;
    for (int i = 0; i < NUM_LAYERS; i++) begin
      if (serving && (idx_q == IDX_W'(i))) begin
        bus.layer_en[i]  = (state_q == S_LAUNCH);
        bus.dram_addr_rd = bus.layer_addr_in[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.dram_addr_wr = bus.layer_addr_out[i*ADDR_WIDTH +: ADDR_WIDTH];
        bus.dram_data_wr = bus.layer_data_out[i*DATA_WIDTH +: DATA_WIDTH];
        bus.dram_en_rd   = bus.layer_dram_en_rd[i];
        bus.dram_en_wr   = bus.layer_dram_en_wr[i];
      end
    end
  end

  assign bus.busy        = (state_q == S_SEL) || serving;
  assign bus.done        = (state_q == S_DONE);
  assign bus.error       = err_q;
  assign bus.cur_layer   = idx_q;
  assign bus.last_cycles = last_q;
endmodule

// File: tb/tb_layer_scheduler.sv
// Scoreboard bench for layer_scheduler: behavioural engine models, an expected-event
// queue filled at each start, and a monitor that checks events and the DRAM port.
module tb_layer_scheduler;
  localparam int DW = 32;
  localparam int AW = 18;
  localparam int NL = 4;
  localparam int CW = 24;
  localparam int TO = 16;
  localparam int K_LAUNCH = 0;
  localparam int K_DONE   = 1;
  localparam int K_ERR    = 2;

  typedef struct {
    int kind;
    int layer;
    int offset;
    int last;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  layer_scheduler_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LAYERS(NL), .CNT_WIDTH(CW)) bus ();

  layer_scheduler #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .NUM_LAYERS(NL), .CNT_WIDTH(CW), .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  ev_t q[$];
  int  errors     = 0;
  int  checks     = 0;
  int  start_cyc  = 0;
  bit  run_active = 1'b0;
  int  busy_low   = 0;
  int  model_last = 0;
  int  hang_l     = -1;
  bit  spur_en    = 1'b0;
  int  lat [NL];
  bit  svc [NL];
  bit  fin [NL];
  int  rem [NL];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [127:0] outs();
    return 128'({bus.busy, bus.done, bus.error, bus.layer_en, bus.cur_layer, bus.last_cycles,
                 bus.dram_addr_rd, bus.dram_addr_wr, bus.dram_data_wr, bus.dram_en_rd, bus.dram_en_wr});
  endfunction

  // Engines: done arrives lat cycles after the enable; a hung engine never answers and is
  // given up after TO waiting cycles. Idle engines may raise stray done pulses.
  initial begin
    logic [NL-1:0] dv;
    for (int i = 0; i < NL; i++) begin
      svc[i] = 1'b0;
      fin[i] = 1'b0;
      rem[i] = 0;
    end
    bus.layer_done       = '0;
    bus.layer_addr_in    = '0;
    bus.layer_addr_out   = '0;
    bus.layer_data_out   = '0;
    bus.layer_dram_en_rd = '0;
    bus.layer_dram_en_wr = '0;
    forever begin
      @(posedge clk);
      #1;
      dv = '0;
      for (int i = 0; i < NL; i++) begin
        if (rst) begin
          svc[i] = 1'b0;
          fin[i] = 1'b0;
        end else begin
          if (fin[i]) begin
            svc[i] = 1'b0;
            fin[i] = 1'b0;
          end
          if (bus.layer_en[i]) begin
            svc[i] = 1'b1;
            rem[i] = (hang_l == i) ? TO : lat[i];
          end else if (svc[i]) begin
            rem[i]--;
            if (rem[i] == 0) begin
              fin[i] = 1'b1;
              dv[i]  = (hang_l != i);
            end
          end else if (spur_en && ($urandom_range(0, 5) == 0)) begin
            dv[i] = 1'b1;
          end
        end
      end
      bus.layer_done = dv;
      for (int i = 0; i < NL; i++) begin
        bus.layer_addr_in[i*AW +: AW]  = AW'($urandom);
        bus.layer_addr_out[i*AW +: AW] = AW'($urandom);
        bus.layer_data_out[i*DW +: DW] = $urandom;
      end
      bus.layer_dram_en_rd = NL'($urandom);
      bus.layer_dram_en_wr = NL'($urandom);
    end
  end

  // Monitor
  initial begin
    bit            prev_err;
    int            act;
    logic [AW-1:0] e_ard, e_awr;
    logic [DW-1:0] e_d;
    logic          e_rd, e_wr;
    ev_t           e;
    prev_err = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_err = 1'b0;
        continue;
      end
      act = -1;
      for (int i = 0; i < NL; i++) if (svc[i]) act = i;
      e_ard = '0; e_awr = '0; e_d = '0; e_rd = 1'b0; e_wr = 1'b0;
      if (act >= 0) begin
        e_ard = bus.layer_addr_in[act*AW +: AW];
        e_awr = bus.layer_addr_out[act*AW +: AW];
        e_d   = bus.layer_data_out[act*DW +: DW];
        e_rd  = bus.layer_dram_en_rd[act];
        e_wr  = bus.layer_dram_en_wr[act];
      end
      chk("dram_port",
          128'({bus.dram_addr_rd, bus.dram_addr_wr, bus.dram_data_wr, bus.dram_en_rd, bus.dram_en_wr}),
          128'({e_ard, e_awr, e_d, e_rd, e_wr}));
      if (run_active && (cyc > start_cyc) && !bus.busy && !bus.done && !(bus.error && !prev_err))
        busy_low++;

      if (bus.layer_en != '0) begin
        if (q.size() == 0) chk("unexpected_launch", 128'(bus.layer_en), 128'(0));
        else begin
          e = q.pop_front();
          chk("launch_kind", 128'(K_LAUNCH), 128'(e.kind));
          chk("launch_en", 128'(bus.layer_en), 128'(1) << e.layer);
          chk("launch_offset", 128'(cyc - start_cyc), 128'(e.offset));
          chk("launch_last", 128'(bus.last_cycles), 128'(e.last));
          chk("launch_cur", 128'(bus.cur_layer), 128'(e.layer));
          chk("launch_error", 128'(bus.error), 128'(0));
        end
      end
      if (bus.done) begin
        if (q.size() == 0) chk("unexpected_done", 128'(bus.done), 128'(0));
        else begin
          e = q.pop_front();
          chk("done_kind", 128'(K_DONE), 128'(e.kind));
          chk("done_offset", 128'(cyc - start_cyc), 128'(e.offset));
          chk("done_last", 128'(bus.last_cycles), 128'(e.last));
          chk("done_cur", 128'(bus.cur_layer), 128'(NL));
          chk("done_busy", 128'(bus.busy), 128'(0));
          chk("busy_glitch", 128'(busy_low), 128'(0));
          run_active = 1'b0;
        end
      end
      if (bus.error && !prev_err) begin
        if (q.size() == 0) chk("unexpected_error", 128'(bus.error), 128'(0));
        else begin
          e = q.pop_front();
          chk("err_kind", 128'(K_ERR), 128'(e.kind));
          chk("err_offset", 128'(cyc - start_cyc), 128'(e.offset));
          chk("err_cur", 128'(bus.cur_layer), 128'(e.layer));
          chk("err_busy", 128'(bus.busy), 128'(0));
          chk("busy_glitch", 128'(busy_low), 128'(0));
          run_active = 1'b0;
        end
      end
      prev_err = bus.error;
    end
  end

  // Reference: a skipped layer costs one cycle, a run layer costs SEL + LAUNCH + its
  // latency; after the last index one more SEL cycle precedes the DONE cycle.
  task automatic push_run(input logic [NL-1:0] m);
    int  t;
    ev_t e;
    t = 1;
    for (int i = 0; i < NL; i++) begin
      if (!m[i]) t += 1;
      else begin
        e.kind = K_LAUNCH; e.layer = i; e.offset = t + 1; e.last = model_last;
        q.push_back(e);
        if (i == hang_l) begin
          e.kind = K_ERR; e.offset = t + 2 + TO;
          q.push_back(e);
          return;
        end
        t += lat[i] + 2;
        model_last = lat[i];
      end
    end
    e.kind = K_DONE; e.layer = NL; e.offset = t + 1; e.last = model_last;
    q.push_back(e);
  endtask

  task automatic set_lat();
    for (int i = 0; i < NL; i++) lat[i] = $urandom_range(1, 12);
  endtask

  // A second start pulse and a new mask arrive mid-run and must be ignored.
  task automatic start_run(input logic [NL-1:0] m);
    @(posedge clk); #1;
    bus.start      = 1'b1;
    bus.layer_mask = m;
    start_cyc      = cyc;
    busy_low       = 0;
    run_active     = 1'b1;
    push_run(m);
    @(posedge clk); #1;
    bus.start      = 1'b0;
    bus.layer_mask = NL'($urandom);
    @(posedge clk); #1;
    @(posedge clk); #1;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || run_active) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("run_drained", 128'(q.size()), 128'(0));
    q.delete();
    run_active = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int n;
    bus.start      = 1'b0;
    bus.layer_mask = '0;
    for (int i = 0; i < NL; i++) lat[i] = 10;
    repeat (3) @(negedge clk);
    chk("reset_outputs", outs(), 128'(0));
    #1 rst = 1'b0;
    repeat (2) @(negedge clk);

    start_run(4'b1111);
    wait_idle();

    set_lat();
    start_run(4'b0101);
    wait_idle();

    spur_en = 1'b1;
    start_run(4'b0000);
    wait_idle();

    // Engine 0 hangs: watchdog, then a restart straight out of ERR.
    spur_en = 1'b0;
    set_lat();
    hang_l = 0;
    start_run(4'b1011);
    wait_idle();
    repeat (5) @(negedge clk);
    hang_l = -1;
    set_lat();
    start_run(4'b1111);
    wait_idle();

    // Reset while layer 2 is being served.
    set_lat();
    start_run(4'b1111);
    n = 0;
    while (!svc[2] && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("reached_layer2", 128'(svc[2]), 128'(1));
    @(negedge clk);
    #1 rst = 1'b1;
    #1;
    chk("rst_async", outs(), 128'(0));
    q.delete();
    run_active = 1'b0;
    model_last = 0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b0;
    set_lat();
    start_run(4'b1111);
    wait_idle();

    spur_en = 1'b1;
    repeat (20) begin
      set_lat();
      start_run(NL'($urandom));
      wait_idle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
